// File: rtl/sys_fence_sequencer.sv
// Sequences the store-buffer drain, D-cache write-back, I-cache invalidate and TLB flush
// side effects of FENCE, FENCE.I and SFENCE.VMA. Define SYS_FENCE_DCACHE_WB_EN for a write-back D-cache.
module sys_fence_sequencer #(
   parameter int XLEN   = 64,
   parameter int ASID_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Flush,
   input  logic              fence_req,
   input  logic [11:0]       fence_data,
   input  logic              fencei_req,
   input  logic              sfence_req,
   input  logic [XLEN-1:0]   sfence_vaddr,
   input  logic [XLEN-1:0]   sfence_asid,
   input  logic              sb_empty,
   output logic              dc_wb_req,
   input  logic              dc_wb_ack,
   output logic              ic_inv_req,
   input  logic              ic_inv_ack,
   output logic              tlb_flush_req,
   output logic [XLEN-1:0]   tlb_flush_vaddr,
   output logic [ASID_W-1:0] tlb_flush_asid,
   output logic              tlb_flush_all_va,
   output logic              tlb_flush_all_asid,
   input  logic              itlb_ack,
   input  logic              dtlb_ack,
   output logic              fence_done,
   output logic              fencei_done,
   output logic              sfence_done,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SB_DRAIN,
      ST_DC_WB,
      ST_IC_INV,
      ST_TLB_FLUSH,
      ST_DONE,
      ST_ABORT
   } state_e;

   typedef enum logic [1:0] {
      K_NONE,
      K_FENCE,
      K_FENCEI,
      K_SFENCE
   } kind_e;

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic              latch_ops;
   logic [XLEN-1:0]   vaddr_q;
   logic [ASID_W-1:0] asid_q;
   logic              all_va_q, all_asid_q;
   logic              dc_wb_req_q, dc_wb_req_d;
   logic              ic_inv_req_q, ic_inv_req_d;
   logic              tlb_req_q, tlb_req_d;
   logic              itlb_seen_q, dtlb_seen_q, clear_sticky;
   logic              fence_done_q, fence_done_d;
   logic              fencei_done_q, fencei_done_d;
   logic              sfence_done_q, sfence_done_d;
   logic              fence_needs_drain;
   logic              dc_ack_ok, ic_ack_ok, tlb_ack_ok;

   // fm and the remaining pred/succ bits do not change what this block does.
   logic [9:0] unused_fence_bits;
   assign unused_fence_bits = {fence_data[11:7], fence_data[5], fence_data[3:0]};

   // Only a prior store (pred.W) or prior device output (pred.O) needs the store buffer drained.
   assign fence_needs_drain = fence_data[4] | fence_data[6];

   // Acks count only while the matching request is up.
   assign dc_ack_ok  = dc_wb_req_q & dc_wb_ack;
   assign ic_ack_ok  = ic_inv_req_q & ic_inv_ack;
   assign tlb_ack_ok = tlb_req_q & (itlb_seen_q | itlb_ack) & (dtlb_seen_q | dtlb_ack);

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no path infers a latch.
      state_d       = state_q;
      kind_d        = kind_q;
      latch_ops     = 1'b0;
      fence_done_d  = 1'b0;
      fencei_done_d = 1'b0;
      sfence_done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sfence_req) begin
               kind_d    = K_SFENCE;
               latch_ops = 1'b1;
               state_d   = ST_SB_DRAIN;
            end else if (fencei_req) begin
               kind_d  = K_FENCEI;
               state_d = ST_SB_DRAIN;
            end else if (fence_req) begin
               kind_d  = K_FENCE;
               state_d = fence_needs_drain ? ST_SB_DRAIN : ST_DONE;
            end
         end
         ST_SB_DRAIN: begin
            if (Flush) begin
               state_d = ST_IDLE;
            end else if (sb_empty) begin
               case (kind_q)
`ifdef SYS_FENCE_DCACHE_WB_EN
                  K_FENCEI: state_d = ST_DC_WB;
`else
                  K_FENCEI: state_d = ST_IC_INV;
`endif
                  K_SFENCE: state_d = ST_TLB_FLUSH;
                  default:  state_d = ST_DONE;
               endcase
            end
         end
         ST_DC_WB: begin
            // An ack coinciding with Flush leaves nothing outstanding, so skip ABORT.
            if (dc_ack_ok)  state_d = Flush ? ST_IDLE : ST_IC_INV;
            else if (Flush) state_d = ST_ABORT;
         end
         ST_IC_INV: begin
            if (ic_ack_ok)  state_d = Flush ? ST_IDLE : ST_DONE;
            else if (Flush) state_d = ST_ABORT;
         end
         ST_TLB_FLUSH: begin
            if (tlb_ack_ok) state_d = Flush ? ST_IDLE : ST_DONE;
            else if (Flush) state_d = ST_ABORT;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (!Flush) begin
               fence_done_d  = (kind_q == K_FENCE);
               fencei_done_d = (kind_q == K_FENCEI);
               sfence_done_d = (kind_q == K_SFENCE);
            end
         end
         ST_ABORT: begin
            // Exactly one request is still up; wait out its ack so the resource is left quiet.
            if (dc_ack_ok || ic_ack_ok || tlb_ack_ok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      dc_wb_req_d  = (state_d == ST_DC_WB)     || ((state_d == ST_ABORT) && dc_wb_req_q);
      ic_inv_req_d = (state_d == ST_IC_INV)    || ((state_d == ST_ABORT) && ic_inv_req_q);
      tlb_req_d    = (state_d == ST_TLB_FLUSH) || ((state_d == ST_ABORT) && tlb_req_q);
      clear_sticky = (state_d == ST_TLB_FLUSH) && (state_q != ST_TLB_FLUSH);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q       <= ST_IDLE;
         kind_q        <= K_NONE;
         vaddr_q       <= '0;
         asid_q        <= '0;
         all_va_q      <= 1'b0;
         all_asid_q    <= 1'b0;
         dc_wb_req_q   <= 1'b0;
         ic_inv_req_q  <= 1'b0;
         tlb_req_q     <= 1'b0;
         itlb_seen_q   <= 1'b0;
         dtlb_seen_q   <= 1'b0;
         fence_done_q  <= 1'b0;
         fencei_done_q <= 1'b0;
         sfence_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         dc_wb_req_q   <= dc_wb_req_d;
         ic_inv_req_q  <= ic_inv_req_d;
         tlb_req_q     <= tlb_req_d;
         fence_done_q  <= fence_done_d;
         fencei_done_q <= fencei_done_d;
         sfence_done_q <= sfence_done_d;
         if (latch_ops) begin
            vaddr_q    <= sfence_vaddr;
            asid_q     <= sfence_asid[ASID_W-1:0];
            all_va_q   <= (sfence_vaddr == '0);
            all_asid_q <= (sfence_asid == '0);
         end
         if (clear_sticky) begin
            itlb_seen_q <= 1'b0;
            dtlb_seen_q <= 1'b0;
         end else if (tlb_req_q) begin
            itlb_seen_q <= itlb_seen_q | itlb_ack;
            dtlb_seen_q <= dtlb_seen_q | dtlb_ack;
         end
      end
   end

`ifdef SYS_FENCE_DCACHE_WB_EN
   assign dc_wb_req = dc_wb_req_q;
`else
   assign dc_wb_req = 1'b0;
`endif
   assign ic_inv_req         = ic_inv_req_q;
   assign tlb_flush_req      = tlb_req_q;
   assign tlb_flush_vaddr    = vaddr_q;
   assign tlb_flush_asid     = asid_q;
   assign tlb_flush_all_va   = all_va_q;
   assign tlb_flush_all_asid = all_asid_q;
   assign fence_done         = fence_done_q;
   assign fencei_done        = fencei_done_q;
   assign sfence_done        = sfence_done_q;
   assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sys_fence_sequencer.sv
// Scoreboard bench for sys_fence_sequencer: stimulus pushes expected events (request rises, done
// pulses with their cycle), a negedge monitor pops and compares them.
module tb_sys_fence_sequencer;

   localparam int KF = 0;
   localparam int KI = 1;
   localparam int KS = 2;

   typedef enum int {EV_DC, EV_IC, EV_TLB, EV_FD, EV_FID, EV_SD} ev_e;
   typedef struct {
      ev_e         ev;
      int          cyc;
      logic [63:0] va;
      logic [15:0] asid;
      logic [1:0]  flags;
   } exp_t;

   logic        clk, rst, Flush;
   logic        fence_req, fencei_req, sfence_req;
   logic [11:0] fence_data;
   logic [63:0] sfence_vaddr, sfence_asid;
   logic        sb_empty;
   logic        dc_wb_req, dc_wb_ack, ic_inv_req, ic_inv_ack;
   logic        tlb_flush_req, tlb_flush_all_va, tlb_flush_all_asid;
   logic [63:0] tlb_flush_vaddr;
   logic [15:0] tlb_flush_asid;
   logic        itlb_ack, dtlb_ack;
   logic        fence_done, fencei_done, sfence_done, busy;

   int   cyc = 0;
   int   sb_rise = 0;
   int   dc_lat = 1, ic_lat = 1, itlb_lat = 1, dtlb_lat = 1;
   int   errors = 0, checks = 0;
   exp_t sb_q[$];

   sys_fence_sequencer #(.XLEN(64), .ASID_W(16)) dut (
      .clk(clk), .rst(rst), .Flush(Flush),
      .fence_req(fence_req), .fence_data(fence_data), .fencei_req(fencei_req),
      .sfence_req(sfence_req), .sfence_vaddr(sfence_vaddr), .sfence_asid(sfence_asid),
      .sb_empty(sb_empty),
      .dc_wb_req(dc_wb_req), .dc_wb_ack(dc_wb_ack),
      .ic_inv_req(ic_inv_req), .ic_inv_ack(ic_inv_ack),
      .tlb_flush_req(tlb_flush_req), .tlb_flush_vaddr(tlb_flush_vaddr),
      .tlb_flush_asid(tlb_flush_asid), .tlb_flush_all_va(tlb_flush_all_va),
      .tlb_flush_all_asid(tlb_flush_all_asid),
      .itlb_ack(itlb_ack), .dtlb_ack(dtlb_ack),
      .fence_done(fence_done), .fencei_done(fencei_done), .sfence_done(sfence_done),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   function automatic exp_t mk(input ev_e ev, input int c);
      exp_t e;
      e.ev = ev; e.cyc = c; e.va = '0; e.asid = '0; e.flags = '0;
      return e;
   endfunction

   // Pushes the expected event sequence for one request first high in cycle t0; returns the
   // cycle in which its done pulse is expected. Each handshake stage lasts (ack latency + 1).
   function automatic int push_txn(input int k, input int t0, input logic [11:0] fd,
                                   input logic [63:0] va, input logic [63:0] as, input bit want_done);
      exp_t e;
      int   t;
      int   t_done;
      if (k == KF && !(fd[4] || fd[6])) begin
         t_done = t0 + 2;
      end else begin
         t = (sb_rise > t0 + 1) ? sb_rise : t0 + 1;
         if (k == KI) begin
`ifdef SYS_FENCE_DCACHE_WB_EN
            sb_q.push_back(mk(EV_DC, -1));
            t = t + 1 + dc_lat;
`endif
            sb_q.push_back(mk(EV_IC, -1));
            t = t + 1 + ic_lat;
         end else if (k == KS) begin
            e = mk(EV_TLB, -1);
            e.va = va; e.asid = as[15:0]; e.flags = {va == 64'd0, as == 64'd0};
            sb_q.push_back(e);
            t = t + 1 + ((itlb_lat > dtlb_lat) ? itlb_lat : dtlb_lat);
         end
         t_done = t + 2;
      end
      if (want_done) sb_q.push_back(mk(k == KF ? EV_FD : (k == KI ? EV_FID : EV_SD), t_done));
      return t_done;
   endfunction

   // ---------------- monitor ----------------
   task automatic expect_ev(input ev_e ev);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event @cycle %0d: got %s, required none", cyc, ev.name());
      end else begin
         e = sb_q.pop_front();
         check("event_kind", 64'(ev), 64'(e.ev));
         if (e.cyc >= 0) check("done_cycle", 64'(cyc), 64'(e.cyc));
         if (ev == EV_TLB) begin
            check("tlb_vaddr", tlb_flush_vaddr, e.va);
            check("tlb_asid", 64'(tlb_flush_asid), 64'(e.asid));
            check("tlb_all_flags", 64'({tlb_flush_all_va, tlb_flush_all_asid}), 64'(e.flags));
         end
      end
   endtask

   initial begin : monitor
      logic dc_p, ic_p, tlb_p;
      dc_p = 1'b0; ic_p = 1'b0; tlb_p = 1'b0;
      forever begin
         @(negedge clk);
         if (dc_wb_req && !dc_p)      expect_ev(EV_DC);
         if (ic_inv_req && !ic_p)     expect_ev(EV_IC);
         if (tlb_flush_req && !tlb_p) expect_ev(EV_TLB);
         if (fence_done)  expect_ev(EV_FD);
         if (fencei_done) expect_ev(EV_FID);
         if (sfence_done) expect_ev(EV_SD);
         if (dc_wb_req || ic_inv_req || tlb_flush_req)
            check("req_exclusive", 64'($countones({dc_wb_req, ic_inv_req, tlb_flush_req})), 64'd1);
         if (fence_done || fencei_done || sfence_done)
            check("done_exclusive", 64'($countones({fence_done, fencei_done, sfence_done})), 64'd1);
         dc_p = dc_wb_req; ic_p = ic_inv_req; tlb_p = tlb_flush_req;
      end
   end

   // ---------------- environment responders ----------------
   initial begin : sb_drv
      sb_empty = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         sb_empty = (cyc >= sb_rise);
      end
   end

   initial begin : dc_resp
      dc_wb_ack = 1'b0;
      forever begin
         tick();
         if (dc_wb_req) begin
            repeat (dc_lat) tick();
            dc_wb_ack = 1'b1; tick(); dc_wb_ack = 1'b0;
            for (int i = 0; i < 1000 && dc_wb_req; i++) tick();
         end
      end
   end

   initial begin : ic_resp
      ic_inv_ack = 1'b0;
      forever begin
         tick();
         if (ic_inv_req) begin
            repeat (ic_lat) tick();
            ic_inv_ack = 1'b1; tick(); ic_inv_ack = 1'b0;
            for (int i = 0; i < 1000 && ic_inv_req; i++) tick();
         end
      end
   end

   initial begin : itlb_resp
      itlb_ack = 1'b0;
      forever begin
         tick();
         if (tlb_flush_req) begin
            repeat (itlb_lat) tick();
            itlb_ack = 1'b1; tick(); itlb_ack = 1'b0;
            for (int i = 0; i < 1000 && tlb_flush_req; i++) tick();
         end
      end
   end

   initial begin : dtlb_resp
      dtlb_ack = 1'b0;
      forever begin
         tick();
         if (tlb_flush_req) begin
            repeat (dtlb_lat) tick();
            dtlb_ack = 1'b1; tick(); dtlb_ack = 1'b0;
            for (int i = 0; i < 1000 && tlb_flush_req; i++) tick();
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic done_of(input int k);
      return (k == KF) ? fence_done : ((k == KI) ? fencei_done : sfence_done);
   endfunction

   task automatic drop_reqs();
      fence_req = 1'b0; fencei_req = 1'b0; sfence_req = 1'b0;
   endtask

   task automatic run_txn(input int k, input logic [11:0] fd, input logic [63:0] va,
                          input logic [63:0] as, input int sb_delay);
      bit got;
      tick();
      sb_rise = cyc + sb_delay;
      fence_data = fd; sfence_vaddr = va; sfence_asid = as;
      case (k)
         KF:      fence_req = 1'b1;
         KI:      fencei_req = 1'b1;
         default: sfence_req = 1'b1;
      endcase
      void'(push_txn(k, cyc, fd, va, as, 1'b1));
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         tick();
         if (i == 0) check("busy_after_accept", 64'(busy), 64'd1);
         if (done_of(k)) begin
            drop_reqs();
            got = 1'b1;
         end
      end
      if (!got) begin
         check("txn_timeout", 64'd0, 64'd1);
         drop_reqs();
      end
   endtask

   initial begin : stim
      int  ds;
      int  s;
      bit  got_s, got_f;
      logic [63:0] va, as;

      rst = 1'b1; Flush = 1'b0;
      fence_req = 1'b0; fencei_req = 1'b0; sfence_req = 1'b0;
      fence_data = '0; sfence_vaddr = '0; sfence_asid = '0;
      repeat (3) tick();
      check("reset_ctrl", 64'({dc_wb_req, ic_inv_req, tlb_flush_req, tlb_flush_all_va,
                               tlb_flush_all_asid, fence_done, fencei_done, sfence_done, busy}), 64'd0);
      check("reset_vaddr", tlb_flush_vaddr, 64'd0);
      check("reset_asid", 64'(tlb_flush_asid), 64'd0);
      rst = 1'b0;
      tick();

      // FENCE with pred.W, store buffer busy for 5 cycles.
      run_txn(KF, 12'h033, 64'd0, 64'd0, 5);
      // FENCE without pred.W/O: straight to DONE.
      run_txn(KF, 12'h8A3, 64'd0, 64'd0, 3);
      // FENCE.I with a slow write-back and quicker invalidate.
      dc_lat = 4; ic_lat = 2;
      run_txn(KI, 12'h000, 64'd0, 64'd0, 1);
      // SFENCE.VMA, D-TLB acks two cycles before the I-TLB.
      dtlb_lat = 1; itlb_lat = 3;
      run_txn(KS, 12'h000, 64'h8000_1000, 64'd0, 0);
      dtlb_lat = 2; itlb_lat = 2;
      run_txn(KS, 12'h000, 64'd0, 64'h0001_0005, 2);

      // Flush during IC_INV: request held until the ack, no done, FENCE pulsed in ABORT ignored.
      tick();
      dc_lat = 2; ic_lat = 4; sb_rise = cyc;
      fencei_req = 1'b1;
      void'(push_txn(KI, cyc, 12'h000, 64'd0, 64'd0, 1'b0));
      for (int i = 0; i < 100 && !ic_inv_req; i++) tick();
      check("abort_ic_req_seen", 64'(ic_inv_req), 64'd1);
      s = cyc;
      tick(); Flush = 1'b1; fencei_req = 1'b0;
      tick(); Flush = 1'b0; fence_req = 1'b1; fence_data = 12'h000;
      tick(); fence_req = 1'b0;
      tick();
      check("abort_req_held", 64'(ic_inv_req), 64'd1);
      check("abort_busy", 64'(busy), 64'd1);
      check("abort_ack_cycle", 64'(cyc), 64'(s + ic_lat));
      tick();
      check("abort_req_dropped", 64'(ic_inv_req), 64'd0);
      check("abort_idle", 64'(busy), 64'd0);
      repeat (4) tick();
      check("abort_fence_ignored", 64'(busy), 64'd0);

      // SFENCE and FENCE together: SFENCE first, then the still-held FENCE.
      tick();
      itlb_lat = 2; dtlb_lat = 4; sb_rise = cyc + 2;
      sfence_req = 1'b1; fence_req = 1'b1; fence_data = 12'h0F0;
      sfence_vaddr = 64'h0000_7fff_ffff_f000; sfence_asid = 64'h3;
      ds = push_txn(KS, cyc, 12'h0F0, sfence_vaddr, sfence_asid, 1'b1);
      void'(push_txn(KF, ds, 12'h0F0, 64'd0, 64'd0, 1'b1));
      got_s = 1'b0; got_f = 1'b0;
      for (int i = 0; i < 300 && !(got_s && got_f); i++) begin
         tick();
         if (sfence_done) begin sfence_req = 1'b0; got_s = 1'b1; end
         if (fence_done)  begin fence_req = 1'b0;  got_f = 1'b1; end
      end
      check("prio_both_done", 64'({got_s, got_f}), 64'h3);
      drop_reqs();

      // Reset in the middle of TLB_FLUSH.
      tick();
      itlb_lat = 6; dtlb_lat = 6; sb_rise = cyc;
      sfence_vaddr = 64'h1234_5000; sfence_asid = 64'h7; sfence_req = 1'b1;
      void'(push_txn(KS, cyc, 12'h000, sfence_vaddr, sfence_asid, 1'b0));
      for (int i = 0; i < 100 && !tlb_flush_req; i++) tick();
      check("rst_tlb_req_seen", 64'(tlb_flush_req), 64'd1);
      tick(); rst = 1'b1; sfence_req = 1'b0;
      tick(); rst = 1'b0;
      check("rst_ctrl", 64'({dc_wb_req, ic_inv_req, tlb_flush_req, tlb_flush_all_va,
                             tlb_flush_all_asid, fence_done, fencei_done, sfence_done, busy}), 64'd0);
      check("rst_vaddr", tlb_flush_vaddr, 64'd0);
      check("rst_asid", 64'(tlb_flush_asid), 64'd0);
      repeat (20) tick();

      // Randomised back-to-back traffic.
      for (int n = 0; n < 40; n++) begin
         dc_lat = $urandom_range(1, 5); ic_lat = $urandom_range(1, 5);
         itlb_lat = $urandom_range(1, 5); dtlb_lat = $urandom_range(1, 5);
         va = {$urandom, $urandom};
         as = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) va = 64'd0;
         if ($urandom_range(0, 3) == 0) as = 64'd0;
         run_txn($urandom_range(0, 2), 12'($urandom), va, as, $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (10) tick();
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
